// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// the nop word returned for out-of-range fetches, and the word packer.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // First three bytes of a word arrive before the last; big-endian packing.
  function automatic logic [31:0] pack_word(input logic [23:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port,
// whole array cleared by reset.
module imem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Storage update; a same-cycle read sees the pre-write word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Serial program loader: assembles big-endian bytes into words, writes them
// into imem_array, holds the CPU in reset until loading finishes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  input  logic [31:0]   PC,
  output logic [31:0]   instr,
  output logic          cpu_rst,
  output logic [AW:0]   word_count,
  output logic          load_err
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

  state_e      state_q, state_d;
  logic [AW:0] wc_q, wc_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] asm_q, asm_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        accept_s, we_s, in_range_s, pc_unused_s;
  logic [31:0] rdata_s, wdata_s;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load_en) state_d = ST_LOAD; else state_d = ST_IDLE;
      ST_LOAD: if (load_en) state_d = ST_LOAD; else state_d = ST_RUN;
      ST_RUN:  if (load_en) state_d = ST_LOAD; else state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bytes arriving while load_en is already low are dropped.
  assign accept_s = (state_q == ST_LOAD) && load_en && byte_valid && ready_q;
  assign we_s     = accept_s && (idx_q == 2'd3);
  assign wdata_s  = pack_word(asm_q, byte_data);

  // Byte assembly, word counter and error flag
  always_comb begin
    wc_d  = wc_q;
    idx_d = idx_q;
    asm_d = asm_q;
    err_d = err_q;
    if ((state_q != ST_LOAD) && (state_d == ST_LOAD)) begin
      wc_d  = {(AW+1){1'b0}};
      idx_d = 2'd0;
      asm_d = 24'h00_0000;
      err_d = 1'b0;
    end else if ((state_q == ST_LOAD) && !load_en) begin
      idx_d = 2'd0;
      asm_d = 24'h00_0000;
      err_d = err_q | (idx_q != 2'd0);
    end else if (accept_s) begin
      if (idx_q == 2'd3) begin
        wc_d  = wc_q + CNT_ONE;
        idx_d = 2'd0;
      end else begin
        idx_d = idx_q + 2'd1;
        case (idx_q)
          2'd0:    asm_d[23:16] = byte_data;
          2'd1:    asm_d[15:8]  = byte_data;
          2'd2:    asm_d[7:0]   = byte_data;
          default: asm_d        = asm_q;
        endcase
      end
    end else begin
      wc_d = wc_q;
    end
  end

  // Output decode from the upcoming state, registered below
  always_comb begin
    cpu_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_LOAD) && (wc_d < FULL_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wc_q      <= {(AW+1){1'b0}};
      idx_q     <= 2'd0;
      asm_q     <= 24'h00_0000;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      wc_q      <= wc_d;
      idx_q     <= idx_d;
      asm_q     <= asm_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  imem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_s),
    .waddr_i (wc_q[AW-1:0]),
    .wdata_i (wdata_s),
    .raddr_i (PC[AW+1:2]),
    .rdata_o (rdata_s)
  );

  // Byte offset within the word does not affect the fetch.
  assign pc_unused_s = &{1'b1, PC[1:0]};
  assign in_range_s  = (PC[31:AW+2] == {(30-AW){1'b0}});
  assign instr       = in_range_s ? rdata_s : NOP_INSTR;

  assign byte_ready = ready_q;
  assign cpu_rst    = cpu_rst_q;
  assign word_count = wc_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader against a byte-stream model
// of program loading.
module tb_imem_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic [31:0] PC = 32'h0;
  logic        byte_ready, cpu_rst, load_err;
  logic [31:0] instr;
  logic [AW:0] word_count;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .PC(PC), .instr(instr),
    .cpu_rst(cpu_rst), .word_count(word_count), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: a program is the list of bytes accepted in one load.
  logic [31:0] m_mem [DEPTH];
  logic [7:0]  m_part[$];
  bit          m_loading, m_running, m_err, last_acc;
  int          m_acc;

  function automatic void m_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    m_part.delete();
    m_loading = 1'b0; m_running = 1'b0; m_err = 1'b0; m_acc = 0;
  endfunction

  function automatic logic [31:0] m_fetch(input logic [31:0] pc);
    int w;
    w = int'(pc >> 2);
    if (w < DEPTH) return m_mem[w];
    return 32'h0;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    if ($urandom_range(3) != 0) begin
      p = 32'($urandom_range(DEPTH-1)) << 2;
      p[1:0] = 2'($urandom_range(3));
    end else begin
      p = $urandom();
    end
    return p;
  endfunction

  function automatic void expect_now(input logic [31:0] pc);
    sb.push_back('{0, m_fetch(pc)});
    sb.push_back('{1, {31'b0, !m_running}});
    sb.push_back('{2, {31'b0, m_loading && (m_acc < 4*DEPTH)}});
    sb.push_back('{3, 32'(m_acc / 4)});
    sb.push_back('{4, {31'b0, m_err}});
  endfunction

  task automatic cyc(input logic le, input logic bv, input logic [7:0] bd, input logic [31:0] pc);
    bit rdy;
    @(posedge clk); #1;
    load_en = le; byte_valid = bv; byte_data = bd; PC = pc;
    expect_now(pc);
    rdy = m_loading && (m_acc < 4*DEPTH);
    last_acc = 1'b0;
    if (m_loading) begin
      if (le) begin
        if (bv && rdy) begin
          m_part.push_back(bd);
          m_acc++;
          last_acc = 1'b1;
          if (m_part.size() == 4) begin
            m_mem[m_acc/4 - 1] = {m_part[0], m_part[1], m_part[2], m_part[3]};
            m_part.delete();
          end
        end
      end else begin
        m_err = (m_part.size() != 0);
        m_part.delete();
        m_loading = 1'b0;
        m_running = 1'b1;
      end
    end else if (le) begin
      m_loading = 1'b1; m_running = 1'b0; m_err = 1'b0; m_acc = 0;
      m_part.delete();
    end
  endtask

  task automatic apply_reset(input int dly);
    @(posedge clk); #(dly);
    rst = 1'b1; load_en = 1'b0; byte_valid = 1'b0; PC = rand_pc();
    m_clear();
    expect_now(PC);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_now(PC);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard = 0;
    logic v;
    do begin
      v = gaps ? 1'($urandom_range(1)) : 1'b1;
      cyc(1'b1, v, b, rand_pc());
      guard++;
    end while (!last_acc && guard < 200);
    if (!last_acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_byte: byte %h never accepted by model", b);
    end
  endtask

  task automatic run_reads(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom_range(1)), 8'($urandom()), rand_pc());
  endtask

  // Monitor: compares every queued expectation against the DUT at negedge.
  initial begin
    chk_t        e;
    logic [31:0] act;
    string       nm;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.kind)
          0:       begin act = instr;                   nm = "instr";      end
          1:       begin act = {31'b0, cpu_rst};        nm = "cpu_rst";    end
          2:       begin act = {31'b0, byte_ready};     nm = "byte_ready"; end
          3:       begin act = 32'(word_count);         nm = "word_count"; end
          4:       begin act = {31'b0, load_err};       nm = "load_err";   end
          default: begin act = 32'hxxxx_xxxx;           nm = "unknown";    end
        endcase
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s at %0t: got %h expected %h (PC=%h)", nm, $time, act, e.exp, PC);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] prog8 [8];
    int n;
    prog8 = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    m_clear();
    last_acc = 1'b0;
    apply_reset(1);

    // Two-word program, drop load_en with a byte still presented
    cyc(1'b1, 1'b0, 8'h00, 32'h0);
    foreach (prog8[i]) send_byte(prog8[i], 1'b0);
    cyc(1'b0, 1'b1, 8'hAA, 32'h0);
    cyc(1'b0, 1'b0, 8'h00, 32'h4);
    cyc(1'b0, 1'b0, 8'h00, 32'h0);
    cyc(1'b0, 1'b0, 8'h00, 32'h100);
    cyc(1'b0, 1'b0, 8'h00, 32'h7);

    // Partial last word
    cyc(1'b1, 1'b0, 8'h00, 32'h4);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom()), 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 32'h4);
    cyc(1'b0, 1'b0, 8'h00, 32'h4);
    run_reads(4);

    // Overfill: valid held high through ready low
    cyc(1'b1, 1'b0, 8'h00, rand_pc());
    for (int i = 0; i < 4*DEPTH + 4; i++) cyc(1'b1, 1'b1, 8'($urandom()), rand_pc());
    cyc(1'b0, 1'b0, 8'h00, rand_pc());
    run_reads(12);

    // Random lengths with gaps on byte_valid
    for (int r = 0; r < 5; r++) begin
      cyc(1'b1, 1'($urandom_range(1)), 8'($urandom()), rand_pc());
      n = $urandom_range(3, 40);
      for (int i = 0; i < n; i++) send_byte(8'($urandom()), 1'b1);
      cyc(1'b1, 1'b0, 8'h00, rand_pc());
      cyc(1'b0, 1'($urandom_range(1)), 8'($urandom()), rand_pc());
      run_reads(10);
    end

    // Reset mid-word: two bytes into word 3
    cyc(1'b1, 1'b0, 8'h00, rand_pc());
    for (int i = 0; i < 14; i++) send_byte(8'($urandom()), 1'b0);
    apply_reset(3);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 8'h00, rand_pc());

    // Load after reset
    cyc(1'b1, 1'b0, 8'h00, rand_pc());
    for (int i = 0; i < 8; i++) send_byte(8'($urandom()), 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 32'h0);
    run_reads(6);

    @(posedge clk);
    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
